// File: rtl/riskow_pkg.sv
// ============================================================================
// riskow_pkg
// Shared ALU operation codes, RV32I opcode/funct7 constants and OP/OP-IMM decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riskow_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_OR  = 4'd2,
        ALU_XOR = 4'd3,
        ALU_AND = 4'd4,
        ALU_LTU = 4'd5,
        ALU_LTS = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_SLL = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        alu_op_e op;
        logic    illegal;
        logic    use_rs2;
        logic    imm_shamt;
    } decode_t;

    function automatic decode_t decode(input logic [6:0] opc,
                                       input logic [2:0] f3,
                                       input logic [6:0] f7);
        decode_t d;
        d.op        = ALU_ADD;
        d.illegal   = 1'b0;
        d.use_rs2   = 1'b0;
        d.imm_shamt = 1'b0;
        if (opc == OPC_OP) begin
            d.use_rs2 = 1'b1;
            if (f7 != F7_BASE && f7 != F7_ALT)
                d.illegal = 1'b1;
            else if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101)
                d.illegal = 1'b1;
        end else if (opc == OPC_OP_IMM) begin
            // Only the shift immediates reuse the funct7 field.
            d.imm_shamt = (f3 == 3'b001) || (f3 == 3'b101);
            if (f3 == 3'b001 && f7 != F7_BASE)
                d.illegal = 1'b1;
            if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
                d.illegal = 1'b1;
        end else begin
            d.illegal = 1'b1;
        end
        case (f3)
            3'b000: d.op = (opc == OPC_OP && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001: d.op = ALU_SLL;
            3'b010: d.op = ALU_LTS;
            3'b011: d.op = ALU_LTU;
            3'b100: d.op = ALU_XOR;
            3'b101: d.op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110: d.op = ALU_OR;
            3'b111: d.op = ALU_AND;
            default: d.op = ALU_ADD;
        endcase
        if (d.illegal) begin
            d.op        = ALU_ADD;
            d.use_rs2   = 1'b0;
            d.imm_shamt = 1'b0;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_operand_stage_register_file.sv
// ============================================================================
// register_file
// 2 async read ports, 1 sync write port, x0 reads zero, async active-low clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int AW         = $clog2(REG_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr1_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    input  logic [AW-1:0]         raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_COUNT; i++)
                mem_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// alu_operand_stage
// Decodes OP/OP-IMM, fetches operands with scoreboard stall and write-back bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage
    import riskow_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    input  logic [31:0]           instr_i,
    output logic                  instr_ready_o,
    input  logic                  wb_en_i,
    input  logic [4:0]            wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  alu_valid_o,
    input  logic                  alu_ready_i,
    output logic [3:0]            alu_operation_o,
    output logic [DATA_WIDTH-1:0] alu_x_o,
    output logic [DATA_WIDTH-1:0] alu_y_o,
    output logic [4:0]            alu_rd_o,
    output logic                  alu_illegal_o
);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    decode_t    dec;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign dec    = decode(opcode, funct3, funct7);

    logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2;

    register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .AW         (5)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (wb_en_i),
        .waddr_i  (wb_rd_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1),
        .rdata1_o (rf_rd1),
        .raddr2_i (rs2),
        .rdata2_o (rf_rd2)
    );

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic                 wb_live, byp1, byp2, haz1, haz2, hazard, accept;

    // A write-back landing this cycle both resolves the hazard and supplies the operand.
    assign wb_live = wb_en_i && (wb_rd_i != 5'd0);
    assign byp1    = wb_live && (wb_rd_i == rs1);
    assign byp2    = wb_live && (wb_rd_i == rs2);
    assign haz1    = !dec.illegal && (rs1 != 5'd0) && busy_q[rs1] && !byp1;
    assign haz2    = dec.use_rs2 && (rs2 != 5'd0) && busy_q[rs2] && !byp2;
    assign hazard  = haz1 || haz2;

    logic alu_valid_q;

    assign instr_ready_o = (!alu_valid_q || alu_ready_i) && !hazard;
    assign accept        = instr_valid_i && instr_ready_o;

    logic [DATA_WIDTH-1:0] x_d, y_d, imm_sext, imm_shamt;

    assign imm_sext  = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_shamt = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};

    always_comb begin
        x_d = byp1 ? wb_data_i : rf_rd1;
        if (dec.use_rs2)
            y_d = byp2 ? wb_data_i : rf_rd2;
        else if (dec.imm_shamt)
            y_d = imm_shamt;
        else
            y_d = imm_sext;
        if (dec.illegal) begin
            x_d = '0;
            y_d = '0;
        end
    end

    // Set is applied after clear so a younger issue to the same rd wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_live)
            busy_d[wb_rd_i] = 1'b0;
        if (accept && !dec.illegal && rd != 5'd0)
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    alu_op_e               op_q;
    logic [DATA_WIDTH-1:0] x_q, y_q;
    logic [4:0]            rd_q;
    logic                  illegal_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_valid_q <= 1'b0;
            op_q        <= ALU_ADD;
            x_q         <= '0;
            y_q         <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            alu_valid_q <= 1'b1;
            op_q        <= dec.op;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_q        <= dec.illegal ? 5'd0 : rd;
            illegal_q   <= dec.illegal;
        end else if (alu_ready_i) begin
            alu_valid_q <= 1'b0;
        end
    end

    assign alu_valid_o     = alu_valid_q;
    assign alu_operation_o = op_q;
    assign alu_x_o         = x_q;
    assign alu_y_o         = y_q;
    assign alu_rd_o        = rd_q;
    assign alu_illegal_o   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// tb_alu_operand_stage
// Directed vectors with hand-computed expectations for alu_operand_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        instr_ready_o;
    logic        wb_en_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        alu_valid_o;
    logic        alu_ready_i;
    logic [3:0]  alu_operation_o;
    logic [31:0] alu_x_o;
    logic [31:0] alu_y_o;
    logic [4:0]  alu_rd_o;
    logic        alu_illegal_o;

    int n_checks = 0;
    int n_pass   = 0;

    alu_operand_stage dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .instr_valid_i   (instr_valid_i),
        .instr_i         (instr_i),
        .instr_ready_o   (instr_ready_o),
        .wb_en_i         (wb_en_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .alu_valid_o     (alu_valid_o),
        .alu_ready_i     (alu_ready_i),
        .alu_operation_o (alu_operation_o),
        .alu_x_o         (alu_x_o),
        .alu_y_o         (alu_y_o),
        .alu_rd_o        (alu_rd_o),
        .alu_illegal_o   (alu_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        step();
        instr_valid_i = 1'b0;
    endtask

    task automatic writeback(input logic [4:0] r, input logic [31:0] d);
        wb_en_i   = 1'b1;
        wb_rd_i   = r;
        wb_data_i = d;
        step();
        wb_en_i   = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [3:0] op, input logic [31:0] x,
                              input logic [31:0] y, input logic [4:0] rd, input logic ill);
        check({tag, ".valid"},   {31'd0, alu_valid_o},   32'd1);
        check({tag, ".op"},      {28'd0, alu_operation_o}, {28'd0, op});
        check({tag, ".x"},       alu_x_o, x);
        check({tag, ".y"},       alu_y_o, y);
        check({tag, ".rd"},      {27'd0, alu_rd_o},      {27'd0, rd});
        check({tag, ".illegal"}, {31'd0, alu_illegal_o}, {31'd0, ill});
    endtask

    initial begin
        rst_ni        = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 32'd0;
        wb_en_i       = 1'b0;
        wb_rd_i       = 5'd0;
        wb_data_i     = 32'd0;
        alu_ready_i   = 1'b1;
        step();
        step();
        check("rst.valid",   {31'd0, alu_valid_o},     32'd0);
        check("rst.op",      {28'd0, alu_operation_o}, 32'd0);
        check("rst.x",       alu_x_o,                  32'd0);
        check("rst.y",       alu_y_o,                  32'd0);
        check("rst.rd",      {27'd0, alu_rd_o},        32'd0);
        check("rst.illegal", {31'd0, alu_illegal_o},   32'd0);
        rst_ni = 1'b1;
        step();

        // add x3,x1,x2 with x1=5, x2=3
        writeback(5'd1, 32'd5);
        writeback(5'd2, 32'd3);
        instr_valid_i = 1'b1;
        instr_i       = 32'h002081B3;
        #1;
        check("add.ready", {31'd0, instr_ready_o}, 32'd1);
        step();
        instr_valid_i = 1'b0;
        check_beat("add", 4'd0, 32'd5, 32'd3, 5'd3, 1'b0);

        // reader of x3 must stall on busy[3]
        instr_valid_i = 1'b1;
        instr_i       = 32'h00018433;
        #1;
        check("busy3.ready", {31'd0, instr_ready_o}, 32'd0);
        instr_valid_i = 1'b0;
        step();
        check("drain.valid", {31'd0, alu_valid_o}, 32'd0);

        // addi x4,x0,-1 then srai x5,x4,4 stalled until wb x4
        issue(32'hFFF00213);
        check_beat("addi", 4'd0, 32'd0, 32'hFFFFFFFF, 5'd4, 1'b0);
        instr_valid_i = 1'b1;
        instr_i       = 32'h40425293;
        #1;
        check("srai.stall0", {31'd0, instr_ready_o}, 32'd0);
        step();
        check("srai.stall1", {31'd0, instr_ready_o}, 32'd0);
        step();
        check("srai.stall2", {31'd0, instr_ready_o}, 32'd0);
        wb_en_i   = 1'b1;
        wb_rd_i   = 5'd4;
        wb_data_i = 32'hFFFFFFFF;
        #1;
        check("srai.ready", {31'd0, instr_ready_o}, 32'd1);
        step();
        wb_en_i       = 1'b0;
        instr_valid_i = 1'b0;
        check_beat("srai", 4'd8, 32'hFFFFFFFF, 32'd4, 5'd5, 1'b0);

        // addi x1,x0,7 marks x1 busy; sub x6,x1,x0 bypasses wb x1=0x1234
        issue(32'h00700093);
        check_beat("addi7", 4'd0, 32'd0, 32'd7, 5'd1, 1'b0);
        instr_valid_i = 1'b1;
        instr_i       = 32'h40008333;
        wb_en_i       = 1'b1;
        wb_rd_i       = 5'd1;
        wb_data_i     = 32'h00001234;
        #1;
        check("byp.ready", {31'd0, instr_ready_o}, 32'd1);
        step();
        wb_en_i       = 1'b0;
        instr_valid_i = 1'b0;
        check_beat("sub", 4'd1, 32'h00001234, 32'd0, 5'd6, 1'b0);

        // back-pressure: or x7,x1,x2 waits behind the held sub beat
        alu_ready_i   = 1'b0;
        instr_valid_i = 1'b1;
        instr_i       = 32'h0020E3B3;
        #1;
        check("bp.ready0", {31'd0, instr_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp.hold.op",    {28'd0, alu_operation_o}, 32'd1);
            check("bp.hold.x",     alu_x_o, 32'h00001234);
            check("bp.hold.rd",    {27'd0, alu_rd_o}, 32'd6);
            check("bp.hold.valid", {31'd0, alu_valid_o}, 32'd1);
            check("bp.hold.ready", {31'd0, instr_ready_o}, 32'd0);
        end
        alu_ready_i = 1'b1;
        #1;
        check("bp.ready1", {31'd0, instr_ready_o}, 32'd1);
        step();
        instr_valid_i = 1'b0;
        check_beat("or", 4'd2, 32'h00001234, 32'd3, 5'd7, 1'b0);

        // illegal: ecall, then OP with funct7=0000001; x9 must not be busy
        issue(32'h00000073);
        check_beat("ecall", 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        issue(32'h022084B3);
        check_beat("f7bad", 4'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        instr_valid_i = 1'b1;
        instr_i       = 32'h00048533;
        #1;
        check("x9free.ready", {31'd0, instr_ready_o}, 32'd1);
        step();
        instr_valid_i = 1'b0;
        check_beat("addx10", 4'd0, 32'd0, 32'd0, 5'd10, 1'b0);

        // async reset with a held beat and busy bits outstanding
        alu_ready_i = 1'b0;
        rst_ni      = 1'b0;
        #1;
        check("midrst.valid", {31'd0, alu_valid_o}, 32'd0);
        check("midrst.rd",    {27'd0, alu_rd_o},    32'd0);
        step();
        rst_ni      = 1'b1;
        alu_ready_i = 1'b1;
        step();
        instr_valid_i = 1'b1;
        instr_i       = 32'h001183B3;
        #1;
        check("postrst.ready", {31'd0, instr_ready_o}, 32'd1);
        step();
        instr_valid_i = 1'b0;
        check_beat("postrst", 4'd0, 32'd0, 32'd0, 5'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
